serial_transmitter: RTL and testbench

Byte-serial line transmitter that sits directly downstream of the FIFO-fed transmit scheduler. It accepts one 8-bit word per `start_i` pulse, serialises it as an asynchronous frame (start bit, 8 data bits LSB first, optional parity, stop bits) on a single output lane, and reports `busy_o` back to the scheduler so no new word is issued mid-frame. All timing is derived from the 100 MHz system clock through a programmable bit-period divider.

---
 rtl/serial_transmitter.sv | 139 +++++++++++++
 tb/tb_serial_transmitter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/serial_transmitter.sv
// Byte-serial asynchronous frame transmitter: start bit, 8 data bits LSB first, optional even parity, stop bit(s).
// Optional parity bit is compiled in when SERIAL_TX_PARITY_EN is defined.
module serial_transmitter #(
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk100_i,
    input  logic       rstn_i,
    input  logic [7:0] data_i,
    input  logic       start_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       tx_o
);

    // Handshake: start_i is accepted only on a cycle where busy_o is low; a start_i
    // seen while busy_o is high is dropped, and busy_o rises in the very next cycle.

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef SERIAL_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_d, busy_d, done_d;
    logic             bit_end;
`ifdef SERIAL_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    assign bit_end = (cnt_q == CNT_MAX);

    // State register plus datapath and registered outputs
    always_ff @(posedge clk100_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_o    <= 1'b1;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_o    <= tx_d;
            busy_o  <= busy_d;
            done_o  <= done_d;
`ifdef SERIAL_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_i) state_d = S_START;
            S_START:  if (bit_end) state_d = S_DATA;
            S_DATA: begin
                if (bit_end && bit_q == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: if (bit_end) state_d = S_STOP;
`endif
            S_STOP:   if (bit_end && bit_q == STOP_LAST) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath next values; bit_q doubles as the stop-bit counter in STOP
    always_comb begin
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
`ifdef SERIAL_TX_PARITY_EN
        par_d   = par_q;
`endif
        if (state_q == S_IDLE) begin
            cnt_d = '0;
            bit_d = '0;
            if (start_i) begin
                shift_d = data_i;
`ifdef SERIAL_TX_PARITY_EN
                par_d   = ^data_i;
`endif
            end
        end else begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
            if (bit_end && state_q == S_DATA) begin
                shift_d = {1'b0, shift_q[7:1]};
                bit_d   = bit_q + 3'd1;
            end
            if (bit_end && state_q == S_STOP) begin
                bit_d = (state_d == S_IDLE) ? 3'd0 : bit_q + 3'd1;
            end
        end
    end

    // Output logic, evaluated on the next state so the registered outputs line up with it
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != S_IDLE);
        done_d = (state_q == S_STOP) && (state_d == S_IDLE);
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: tx_d = par_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_serial_transmitter.sv
// Directed bench for serial_transmitter: reset, single frames, start-while-busy,
// back-to-back frames, mid-frame reset and parity (when SERIAL_TX_PARITY_EN is defined).
module tb_serial_transmitter;

    localparam int CPB       = 4;
    localparam int STOP_BITS = 1;
`ifdef SERIAL_TX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    localparam int NBITS = 9 + PBITS + STOP_BITS;
    localparam int F     = NBITS * CPB;

    logic       clk100_i = 1'b0;
    logic       rstn_i   = 1'b0;
    logic [7:0] data_i   = 8'h00;
    logic       start_i  = 1'b0;
    logic       busy_o;
    logic       done_o;
    logic       tx_o;

    int n_checks = 0;
    int n_errors = 0;
    logic [0:0] exp_q[$];

    serial_transmitter #(
        .CLKS_PER_BIT(CPB),
        .STOP_BITS   (STOP_BITS)
    ) dut (
        .clk100_i(clk100_i),
        .rstn_i  (rstn_i),
        .data_i  (data_i),
        .start_i (start_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .tx_o    (tx_o)
    );

    always #5 clk100_i = ~clk100_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk100_i);
        #1;
    endtask

    // Expected line level for every cycle of one frame
    task automatic load_frame(input logic [7:0] d);
        logic b;
        for (int k = 0; k < NBITS; k++) begin
            if (k == 0)
                b = 1'b0;
            else if (k <= 8)
                b = d[k-1];
            else if (PBITS == 1 && k == 9)
                b = ^d;
            else
                b = 1'b1;
            for (int c = 0; c < CPB; c++) exp_q.push_back(b);
        end
    endtask

    task automatic idle_check(input string tag);
        check({tag, "_tx"},   32'(tx_o),   32'd1);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
        check({tag, "_done"}, 32'(done_o), 32'd0);
    endtask

    // Sends one frame; inject_at >= 0 raises an extra start_i (data 0xFF) mid-frame.
    // Returns in the cycle done_o should be high, so a following call is back-to-back.
    task automatic run_frame(input logic [7:0] d, input int inject_at, input string tag);
        logic [0:0] exp_bit;
        load_frame(d);
        data_i  = d;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        data_i  = ~d;
        for (int i = 0; i < F; i++) begin
            if (i == inject_at) begin
                start_i = 1'b1;
                data_i  = 8'hFF;
            end
            exp_bit = exp_q.pop_front();
            check({tag, "_tx"},   32'(tx_o),   32'(exp_bit));
            check({tag, "_busy"}, 32'(busy_o), 32'd1);
            check({tag, "_done"}, 32'(done_o), 32'd0);
            tick();
            start_i = 1'b0;
        end
        check({tag, "_end_busy"}, 32'(busy_o), 32'd0);
        check({tag, "_end_done"}, 32'(done_o), 32'd1);
        check({tag, "_end_tx"},   32'(tx_o),   32'd1);
    endtask

    initial begin
        // Reset held with start_i asserted: nothing may start
        rstn_i  = 1'b0;
        start_i = 1'b1;
        data_i  = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            tick();
            idle_check("reset");
        end
        start_i = 1'b0;
        rstn_i  = 1'b1;
        tick();
        idle_check("post_reset");

        run_frame(8'hA5, -1, "a5");
        tick();
        idle_check("a5_idle");

        run_frame(8'h00, 10, "busy_ign");
        tick();
        idle_check("busy_ign_idle");

        run_frame(8'h3C, -1, "b2b_3c");
        run_frame(8'hC3, -1, "b2b_c3");
        tick();
        idle_check("b2b_idle");

        // Reset during data bit 3 of 0x5A (bit period 4, cycles 16..19)
        data_i  = 8'h5A;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (17) tick();
        check("mid_bit3_tx", 32'(tx_o), 32'd1);
        check("mid_bit3_busy", 32'(busy_o), 32'd1);
        rstn_i = 1'b0;
        tick();
        idle_check("mid_reset");
        rstn_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            idle_check("mid_after");
        end

        run_frame(8'hA5, -1, "after_rst_a5");
        tick();
        run_frame(8'h01, -1, "x01");
        tick();
        idle_check("final_idle");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
